// File: rtl/simple_bus_rr_mem.sv
// Round-robin arbitrated simple_bus memory target with programmable wait states.
// Optional grant timeout: define SIMPLE_BUS_GNT_TIMEOUT_EN.
module simple_bus_rr_mem #(
   parameter int N_MST    = 2,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int WAIT_CYC = 1,
   parameter int TIMEOUT  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_MST-1:0]         req,
   input  logic [N_MST-1:0]         start,
   input  logic [2*N_MST-1:0]       mode,
   input  logic [ADDR_W*N_MST-1:0]  addr,
   input  logic [DATA_W*N_MST-1:0]  wdata,
   input  logic                     avail,
   output logic [N_MST-1:0]         gnt,
   output logic                     rdy,
   output logic [DATA_W-1:0]        rdata,
   output logic                     err,
   output logic [1:0]               dbg_state
);

   localparam int LW = (N_MST > 1) ? $clog2(N_MST) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, BUSY, DONE} state_t;

   state_t              state, state_nx;
   logic [LW-1:0]       last, cur, pick;
   logic                found;
   logic [3:0]          wcnt;
   logic [1:0]          cap_mode;
   logic [ADDR_W-1:0]   cap_addr;
   logic                grant_go, capture, release_go, finish, tmo;
   logic                cur_req, cur_start;
   logic [1:0]          cur_mode;
   logic [ADDR_W-1:0]   cur_addr;
   logic [DATA_W-1:0]   cur_wdata;
   logic [DATA_W-1:0]   mem [2**ADDR_W];

   assign cur_req   = req[cur];
   assign cur_start = start[cur];
   assign cur_mode  = mode[2*cur +: 2];
   assign cur_addr  = addr[ADDR_W*cur +: ADDR_W];
   assign cur_wdata = wdata[DATA_W*cur +: DATA_W];
   assign dbg_state = state;

`ifdef SIMPLE_BUS_GNT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic          tmo_hit;
   assign tmo_hit = (tcnt == TW'(TIMEOUT - 1));
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT == 0);
`endif

   // Search starts just after the last served master, wrapping around.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_MST; k++) begin
         if (!found && req[(int'(last) + k) % N_MST]) begin
            found = 1'b1;
            pick  = LW'((int'(last) + k) % N_MST);
         end
      end
   end

   always_comb begin
      state_nx   = state;
      grant_go   = 1'b0;
      capture    = 1'b0;
      release_go = 1'b0;
      finish     = 1'b0;
      tmo        = 1'b0;
      case (state)
         IDLE: if (avail && found) begin
            state_nx = GRANT;
            grant_go = 1'b1;
         end
         GRANT: begin
            if (cur_start) begin
               state_nx = BUSY;
               capture  = 1'b1;
            end else if (!cur_req) begin
               state_nx   = IDLE;
               release_go = 1'b1;
            end
`ifdef SIMPLE_BUS_GNT_TIMEOUT_EN
            else if (tmo_hit) begin
               state_nx   = IDLE;
               release_go = 1'b1;
               tmo        = 1'b1;
            end
`endif
         end
         BUSY: if (wcnt == 4'd0) begin
            state_nx = DONE;
            finish   = 1'b1;
         end
         DONE: begin
            state_nx   = IDLE;
            release_go = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // rdy/err/rdata default low every cycle so they are single-cycle pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt      <= '0;
         rdy      <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
         last     <= LW'(N_MST - 1);
         cur      <= '0;
         wcnt     <= '0;
         cap_mode <= '0;
         cap_addr <= '0;
      end else begin
         rdy   <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
         if (grant_go) begin
            gnt <= {{(N_MST-1){1'b0}}, 1'b1} << pick;
            cur <= pick;
         end
         if (release_go) begin
            gnt  <= '0;
            last <= cur;
         end
         if (tmo) err <= 1'b1;
         if (capture) begin
            cap_mode <= cur_mode;
            cap_addr <= cur_addr;
            wcnt     <= 4'(WAIT_CYC);
         end
         if (state == BUSY && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
         if (finish) begin
            rdy   <= 1'b1;
            err   <= (cap_mode == 2'b11);
            rdata <= (cap_mode == 2'b01) ? mem[cap_addr] : '0;
         end
      end
   end

`ifdef SIMPLE_BUS_GNT_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          tcnt <= '0;
      else if (grant_go)                   tcnt <= '0;
      else if (state == GRANT && !tmo_hit) tcnt <= tcnt + TW'(1);
   end
`endif

   // Storage is deliberately unreset; the write commits at the capture edge.
   always_ff @(posedge clk) begin
      if (capture && cur_mode == 2'b10) mem[cur_addr] <= cur_wdata;
   end

endmodule

// File: tb/tb_simple_bus_rr_mem.sv
// Directed bench for simple_bus_rr_mem: vector table plus multi-cycle sequences.
module tb_simple_bus_rr_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, start, gnt;
   logic [3:0]  mode;
   logic [15:0] addr, wdata;
   logic        avail, rdy, err;
   logic [7:0]  rdata;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   logic [7:0] got_rdata;
   logic       got_err;

   always #5 clk = ~clk;

   simple_bus_rr_mem #(
      .N_MST(2), .ADDR_W(8), .DATA_W(8), .WAIT_CYC(1), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .start(start), .mode(mode),
      .addr(addr), .wdata(wdata), .avail(avail), .gnt(gnt), .rdy(rdy),
      .rdata(rdata), .err(err), .dbg_state(dbg_state)
   );

   typedef struct {
      logic [1:0]  req, start;
      logic [3:0]  mode;
      logic [15:0] addr, wdata;
      logic        avail;
      logic [1:0]  e_gnt;
      logic        e_rdy, e_err;
      logic [7:0]  e_rdata;
   } vec_t;

   vec_t vq[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic [1:0] r, input logic [1:0] s, input logic [3:0] m,
                      input logic [15:0] a, input logic [15:0] w, input logic [1:0] eg,
                      input logic er, input logic ee, input logic [7:0] ed);
      vec_t v;
      v.req = r; v.start = s; v.mode = m; v.addr = a; v.wdata = w; v.avail = 1'b1;
      v.e_gnt = eg; v.e_rdy = er; v.e_err = ee; v.e_rdata = ed;
      vq.push_back(v);
   endtask

   task automatic idle_inputs();
      req = '0; start = '0; mode = '0; addr = '0; wdata = '0; avail = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // One complete transaction by master m; returns rdata/err seen with rdy.
   task automatic run_txn(input int m, input logic [1:0] md, input logic [7:0] a,
                          input logic [7:0] w);
      int cyc;
      req[m] = 1'b1;
      mode[2*m +: 2] = md;
      addr[8*m +: 8] = a;
      wdata[8*m +: 8] = w;
      cyc = 0;
      tick();
      while (gnt[m] !== 1'b1 && cyc < 20) begin tick(); cyc++; end
      check("txn_grant_wait", 32'(cyc < 20), 32'd1);
      start[m] = 1'b1;
      tick();
      start[m] = 1'b0;
      cyc = 0;
      while (rdy !== 1'b1 && cyc < 20) begin tick(); cyc++; end
      check("txn_rdy_wait", 32'(cyc < 20), 32'd1);
      got_rdata = rdata;
      got_err   = err;
      req[m] = 1'b0;
      tick();
   endtask

   initial begin
      int cyc;
      logic [1:0] exp_g;

      // Reset state
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rdy", 32'(rdy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      rst_n = 1'b1;
      tick();

      // Vector table: inputs for one cycle, outputs expected after the next edge.
      add(2'b01, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b01, 0, 0, 8'h00);
      add(2'b01, 2'b01, 4'h2, 16'h003C, 16'h00A5, 2'b01, 0, 0, 8'h00);
      add(2'b01, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b01, 0, 0, 8'h00);
      add(2'b01, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b01, 1, 0, 8'h00);
      add(2'b00, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b00, 0, 0, 8'h00);
      add(2'b01, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b01, 0, 0, 8'h00);
      add(2'b01, 2'b01, 4'h1, 16'h003C, 16'h0000, 2'b01, 0, 0, 8'h00);
      add(2'b01, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b01, 0, 0, 8'h00);
      add(2'b01, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b01, 1, 0, 8'hA5);
      add(2'b00, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b00, 0, 0, 8'h00);
      add(2'b10, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b10, 0, 0, 8'h00);
      add(2'b10, 2'b10, 4'hC, 16'h3C00, 16'hFF00, 2'b10, 0, 0, 8'h00);
      add(2'b10, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b10, 0, 0, 8'h00);
      add(2'b10, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b10, 1, 1, 8'h00);
      add(2'b00, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b00, 0, 0, 8'h00);
      add(2'b01, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b01, 0, 0, 8'h00);
      add(2'b01, 2'b11, 4'h9, 16'h3C3C, 16'h0000, 2'b01, 0, 0, 8'h00);
      add(2'b01, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b01, 0, 0, 8'h00);
      add(2'b01, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b01, 1, 0, 8'hA5);
      add(2'b00, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b00, 0, 0, 8'h00);

      for (int i = 0; i < vq.size(); i++) begin
         req = vq[i].req; start = vq[i].start; mode = vq[i].mode;
         addr = vq[i].addr; wdata = vq[i].wdata; avail = vq[i].avail;
         tick();
         check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vq[i].e_gnt));
         check($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(vq[i].e_rdy));
         check($sformatf("vec%0d_err", i), 32'(err), 32'(vq[i].e_err));
         check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vq[i].e_rdata));
      end
      idle_inputs();
      tick();

      // Round-robin with both masters requesting continuously
      do_reset();
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         cyc = 0;
         while (gnt === 2'b00 && cyc < 10) begin tick(); cyc++; end
         check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(exp_g));
         check($sformatf("rr%0d_onehot", k), 32'($countones(gnt)), 32'd1);
         start = exp_g;
         tick();
         start = 2'b00;
         cyc = 0;
         while (rdy !== 1'b1 && cyc < 10) begin tick(); cyc++; end
         check($sformatf("rr%0d_rdy_wait", k), 32'(cyc < 10), 32'd1);
         tick();
         check($sformatf("rr%0d_gap", k), 32'(gnt), 32'd0);
      end
      idle_inputs();
      tick();

      // avail gating
      do_reset();
      avail = 1'b0;
      req = 2'b10;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("avail%0d_blocked", k), 32'(gnt), 32'd0);
      end
      avail = 1'b1;
      tick();
      check("avail_grant", 32'(gnt), 32'h2);
      req = 2'b00;
      tick();
      tick();

      // Early release by M0 with M1 pending
      do_reset();
      req = 2'b11;
      tick();
      check("early_gnt0", 32'(gnt), 32'h1);
      req = 2'b10;
      tick();
      check("early_drop", 32'(gnt), 32'h0);
      tick();
      check("early_gnt1", 32'(gnt), 32'h2);
      req = 2'b00;
      tick();
      tick();

      // Reset while BUSY: committed write survives
      do_reset();
      req = 2'b01;
      tick();
      mode = 4'h2; addr = 16'h0010; wdata = 16'h0077; start = 2'b01;
      tick();
      start = 2'b00;
      check("busy_state", 32'(dbg_state), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_gnt", 32'(gnt), 32'd0);
      check("midrst_rdy", 32'(rdy), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      check("midrst_state", 32'(dbg_state), 32'd0);
      idle_inputs();
      tick();
      rst_n = 1'b1;
      tick();
      run_txn(0, 2'b01, 8'h10, 8'h00);
      check("midrst_readback", 32'(got_rdata), 32'h77);
      check("midrst_readback_err", 32'(got_err), 32'd0);
      run_txn(1, 2'b01, 8'h3C, 8'h00);
      check("m1_readback", 32'(got_rdata), 32'hA5);

`ifdef SIMPLE_BUS_GNT_TIMEOUT_EN
      // Granted master idles without start
      do_reset();
      req = 2'b01;
      tick();
      check("tmo_gnt", 32'(gnt), 32'h1);
      cyc = 0;
      while (err !== 1'b1 && cyc < 30) begin tick(); cyc++; end
      check("tmo_cycles", 32'(cyc), 32'd16);
      check("tmo_gnt_drop", 32'(gnt), 32'd0);
      check("tmo_no_rdy", 32'(rdy), 32'd0);
      req = 2'b00;
      tick();
      check("tmo_err_pulse", 32'(err), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/simple_bus_rr_mem.md
Name: simple_bus_rr_mem

Overview:
- Parametrised memory target for the simple_bus handshake (req/gnt/addr/data/mode/start/rdy).
- Generalises the single-requester grant-when-available model:
  - N requesters arbitrated round-robin
  - configurable address and data widths
  - programmable wait states
  - read/write/error modes with returned read data
- Sits between several bus masters (CPU, DMA) and a local RAM on one clock domain.

Parameters:
- N_MST, 2, number of requesting masters (2..8).
- ADDR_W, 8, address width; memory depth = 2**ADDR_W words.
- DATA_W, 8, data word width.
- WAIT_CYC, 1, extra wait states before rdy (0..15).
- TIMEOUT, 16, cycles a granted master may idle before start (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_MST  per-master request
- start  in  N_MST  per-master transfer strobe, 1 cycle
- mode  in  2*N_MST  per-master mode: 00 nop, 01 read, 10 write, 11 reserved
- addr  in  ADDR_W*N_MST  per-master address, slice i = master i
- wdata  in  DATA_W*N_MST  per-master write data
- avail  in  1  target available; 0 blocks new grants
- gnt  out  N_MST  one-hot grant, registered
- rdy  out  1  transfer-complete pulse, 1 cycle
- rdata  out  DATA_W  read data, valid while rdy=1
- err  out  1  error pulse, coincident with rdy or a timeout

Behaviour:
- Reset (rst_n=0, async):
  - gnt=0, rdy=0, err=0, rdata=0, state=IDLE.
  - RR pointer last=N_MST-1, so master 0 has first priority.
  - Memory array is not reset.
- FSM states: IDLE, GRANT, BUSY, DONE.
- IDLE:
  - If avail=1 and req!=0, pick the first requester at or after last+1 (mod N_MST).
  - Set gnt[i]=1 at the next edge and go to GRANT.
  - Latency from req rising to gnt = 1 cycle.
  - If avail=0, stay in IDLE with gnt=0.
- GRANT (gnt[i] held):
  - req[i]=0 before start: drop gnt next edge, go to IDLE, last=i.
  - start[i]=1: capture mode[i], addr[i], wdata[i]; load wait counter with WAIT_CYC; go to BUSY.
  - start[j] from a non-granted master is ignored in every state.
  - mode 10: memory written at the capture edge.
  - mode 00: no memory access.
- BUSY:
  - Counter decrements each cycle; at 0 go to DONE.
  - WAIT_CYC=0 passes straight through, so rdy rises 1 cycle after start is sampled.
  - General rule: rdy rises WAIT_CYC+1 cycles after the start edge.
- DONE:
  - rdy=1 for exactly one cycle.
  - mode 01: rdata = mem[captured addr], read at the DONE edge.
  - mode 00 / 10: rdata=0.
  - mode 11: err=1 with rdy, no memory access, rdata=0.
  - Next edge: gnt=0, last=i, state=IDLE.
  - rdata returns to 0 when rdy falls.
- Minimum gap between consecutive grants: 1 IDLE cycle, so gnt is low for at least one cycle between transactions.
- avail falling during GRANT/BUSY/DONE does not abort the transaction; it only blocks the next grant.
- Simultaneous requests: strict round-robin from last+1.
- A master holding req continuously gets at most one transaction per rotation when others are requesting.
- Reset asserted mid-transaction:
  - Immediate return to reset values.
  - A captured write already committed stays committed; nothing else is written.
- Address out of range is impossible: depth = 2**ADDR_W.

Optional Feature:
- Macro SIMPLE_BUS_GNT_TIMEOUT_EN.
- Defined:
  - In GRANT, a counter counts cycles without start.
  - On reaching TIMEOUT: pulse err=1 (rdy stays 0), drop gnt next edge, last=i, go to IDLE.
  - Counter clears on each new grant.
- Not defined: no counter; a granted master may hold gnt indefinitely with req=1 and no start.

Test Plan:
- Single write/read, N_MST=2, WAIT_CYC=1:
  - M0 writes 0xA5 to addr 0x3C → rdy 2 cycles after start, err=0.
  - M0 then reads 0x3C → rdata=0xA5 while rdy=1.
- Round-robin: req=2'b11 held continuously, 4 transactions → grant order M0,M1,M0,M1; gnt one-hot; at least 1 idle cycle between grants.
- avail gating: avail=0 with req[1]=1 for 5 cycles → gnt=0 throughout; avail=1 → gnt[1]=1 the next cycle.
- Reserved mode: M1 issues mode=11 → rdy=1 and err=1 together, rdata=0, memory contents unchanged (verify by readback).
- Early release: M0 granted, drops req without start → gnt[0]=0 next cycle; pending M1 granted after 1 IDLE cycle.
- Reset mid-BUSY, plus optional feature:
  - rst_n pulsed low during BUSY → gnt/rdy/err=0 immediately, FSM IDLE.
  - With SIMPLE_BUS_GNT_TIMEOUT_EN and TIMEOUT=16: a grant with no start → err pulse after 16 cycles, gnt drops.
